regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the data width of each register.
REQ-002 The block SHALL take parameter ADDR_W, default 5, as the register address width; DEPTH = 2**ADDR_W.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 ctrl_reset  input  1  reset, asynchronous, active-high.
REQ-005 ctrl_writeEnable  input  1  write strobe for ctrl_writeReg.
REQ-006 ctrl_writeReg  input  ADDR_W  write address.
REQ-007 data_writeReg  input  WIDTH  write data.
REQ-008 ctrl_readRegA / ctrl_readRegB  input  ADDR_W each  read addresses, ports A and B.
REQ-009 data_readRegA / data_readRegB  output  WIDTH each  read data, ports A and B.
REQ-010 ctrl_setBusy  input  1  mark ctrl_busyReg as pending (scoreboard set).
REQ-011 ctrl_busyReg  input  ADDR_W  scoreboard set address.
REQ-012 busy_readA / busy_readB  output  1 each  scoreboard bit of the register addressed by ctrl_readRegA / ctrl_readRegB.
REQ-013 ctrl_clear  input  1  start the sequential bulk-clear.
REQ-014 clear_active  output  1  high while the bulk-clear runs.

Function
REQ-015 Register 0 SHALL always read as zero, SHALL ignore writes, and its busy bit SHALL always read 0.
REQ-016 Reads SHALL be combinational: data_readRegX = contents of the addressed register, with no clock latency.
REQ-017 A write SHALL occur on the rising edge when ctrl_writeEnable=1, ctrl_writeReg!=0 and clear_active=0; the new value is visible at the read ports after that edge.
REQ-018 The scoreboard SHALL hold one busy bit per register; the edge with ctrl_setBusy=1, ctrl_busyReg!=0 and clear_active=0 sets the busy bit.
REQ-019 An accepted write SHALL clear the busy bit of ctrl_writeReg on the same edge.
REQ-020 A set and a write to the same register on the same edge SHALL leave the busy bit set, with the write data stored.
REQ-021 Clear FSM states SHALL be IDLE and CLEAR; the FSM is in IDLE out of reset.
REQ-022 In IDLE, ctrl_clear=1 at an edge SHALL move the FSM to CLEAR and load an internal index to 1.
REQ-023 In CLEAR, each edge SHALL zero the register and busy bit at index, then increment index.
REQ-024 The edge that clears index DEPTH-1 SHALL return the FSM to IDLE; CLEAR lasts exactly DEPTH-1 cycles and the index does not wrap.
REQ-025 clear_active SHALL be 1 exactly while the FSM is in CLEAR.
REQ-026 During CLEAR, ctrl_clear SHALL be ignored; writes and scoreboard sets SHALL be dropped; reads SHALL return current, partially cleared contents.

Reset
REQ-027 While ctrl_reset=1, all registers and busy bits SHALL be 0 and the FSM SHALL be in IDLE with index 0, independent of clock.
REQ-028 Reset asserted mid-CLEAR SHALL abort the clear immediately; clear_active=0 and all outputs read 0.
REQ-029 Reset values SHALL be: data_readRegA=0, data_readRegB=0, busy_readA=0, busy_readB=0, clear_active=0.

Configuration
REQ-030 With macro REGFILE_BYPASS_EN defined, a read whose address equals ctrl_writeReg while a write is being accepted (REQ-017 conditions) SHALL return data_writeReg combinationally and SHALL report busy=0 for that register, unless a same-edge set targets it (REQ-020).
REQ-031 Without REGFILE_BYPASS_EN, reads SHALL return only stored contents; a written value appears only after the write edge.

Verification
REQ-032 Write 0xDEADBEEF to r5, then read A=5 and B=0 -> A=0xDEADBEEF, B=0x00000000; a write to r0 of 0x1 reads back 0.
REQ-033 Same cycle: write r7=0x12345678 and readRegA=7 -> with REGFILE_BYPASS_EN A=0x12345678 before the edge; without it, the old value before the edge and 0x12345678 after.
REQ-034 setBusy r9, then readRegA=9 -> busy_readA=1; write r9=0xA5 -> busy_readA=0 the next cycle; set+write r9 together -> busy_readA=1 and data 0xA5.
REQ-035 Fill r1..r31 with nonzero values and pulse ctrl_clear -> clear_active=1 for exactly 31 cycles, all reads 0 afterwards; a write to r3 issued mid-clear is lost.
REQ-036 Start a clear, then assert ctrl_reset at cycle 10 -> clear_active=0 and all registers and busy bits 0 immediately; a write after deassertion succeeds.
REQ-037 Run with WIDTH=16, ADDR_W=3 -> 8 registers, clear lasts 7 cycles, and write/read of 0xFFFF round-trips.

Source files
------------

// File: rtl/regfile_param.sv
// Parameterised register file (r0 hardwired to zero) with a per-register busy scoreboard
// and a sequential bulk-clear engine. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_param #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]  data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]  data_readRegA,
  output logic [WIDTH-1:0]  data_readRegB,
  input  logic              ctrl_setBusy,
  input  logic [ADDR_W-1:0] ctrl_busyReg,
  output logic              busy_readA,
  output logic              busy_readB,
  input  logic              ctrl_clear,
  output logic              clear_active
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              we_ok, set_ok;

  assign clear_active = (state_q == CLEAR);
  assign we_ok  = ctrl_writeEnable && (ctrl_writeReg != '0) && !clear_active;
  assign set_ok = ctrl_setBusy && (ctrl_busyReg != '0) && !clear_active;

  // Next-state: clear engine, writes, then scoreboard set (set wins over write-clear)
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (ctrl_clear) begin
          state_d = CLEAR;
          idx_d   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        regs_d[idx_q] = '0;
        busy_d[idx_q] = 1'b0;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (we_ok) begin
      regs_d[ctrl_writeReg] = data_writeReg;
      busy_d[ctrl_writeReg] = 1'b0;
    end
    if (set_ok) begin
      busy_d[ctrl_busyReg] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Combinational read ports; r0 is never written so it always reads zero
`ifdef REGFILE_BYPASS_EN
  logic byp_a, byp_b;
  assign byp_a = we_ok && (ctrl_readRegA == ctrl_writeReg);
  assign byp_b = we_ok && (ctrl_readRegB == ctrl_writeReg);

  assign data_readRegA = byp_a ? data_writeReg : regs_q[ctrl_readRegA];
  assign data_readRegB = byp_b ? data_writeReg : regs_q[ctrl_readRegB];
  assign busy_readA = byp_a ? (set_ok && (ctrl_busyReg == ctrl_readRegA)) : busy_q[ctrl_readRegA];
  assign busy_readB = byp_b ? (set_ok && (ctrl_busyReg == ctrl_readRegB)) : busy_q[ctrl_readRegB];
`else
  assign data_readRegA = regs_q[ctrl_readRegA];
  assign data_readRegB = regs_q[ctrl_readRegB];
  assign busy_readA    = busy_q[ctrl_readRegA];
  assign busy_readB    = busy_q[ctrl_readRegB];
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default 32x32 instance plus a 16-bit, 8-entry instance.
module tb_regfile_param;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_readRegA, data_readRegB;
  logic        ctrl_setBusy;
  logic [4:0]  ctrl_busyReg;
  logic        busy_readA, busy_readB;
  logic        ctrl_clear;
  logic        clear_active;

  logic        s_reset, s_we, s_clear, s_active;
  logic [2:0]  s_wr, s_ra;
  logic [15:0] s_wdata, s_rdata_a, s_rdata_b;
  logic        s_busy_a, s_busy_b;

  int n_checks = 0;
  int n_errors = 0;
  int n_act;

  always #5 clock = ~clock;

  regfile_param u_dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .ctrl_setBusy     (ctrl_setBusy),
    .ctrl_busyReg     (ctrl_busyReg),
    .busy_readA       (busy_readA),
    .busy_readB       (busy_readB),
    .ctrl_clear       (ctrl_clear),
    .clear_active     (clear_active)
  );

  regfile_param #(.WIDTH(16), .ADDR_W(3)) u_small (
    .clock            (clock),
    .ctrl_reset       (s_reset),
    .ctrl_writeEnable (s_we),
    .ctrl_writeReg    (s_wr),
    .data_writeReg    (s_wdata),
    .ctrl_readRegA    (s_ra),
    .ctrl_readRegB    (3'd0),
    .data_readRegA    (s_rdata_a),
    .data_readRegB    (s_rdata_b),
    .ctrl_setBusy     (1'b0),
    .ctrl_busyReg     (3'd0),
    .busy_readA       (s_busy_a),
    .busy_readB       (s_busy_b),
    .ctrl_clear       (s_clear),
    .clear_active     (s_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = a;
    data_writeReg    = d;
    tick();
    ctrl_writeEnable = 1'b0;
  endtask

  initial begin
    ctrl_reset = 1'b1; ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
    ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd9; ctrl_setBusy = 1'b0; ctrl_busyReg = '0;
    ctrl_clear = 1'b0;
    s_reset = 1'b1; s_we = 1'b0; s_wr = '0; s_wdata = '0; s_ra = '0; s_clear = 1'b0;

    // Reset state
    #2;
    check("rst_dataA", data_readRegA, 32'h0);
    check("rst_dataB", data_readRegB, 32'h0);
    check("rst_busyA", 32'(busy_readA), 32'h0);
    check("rst_busyB", 32'(busy_readB), 32'h0);
    check("rst_active", 32'(clear_active), 32'h0);
    tick();
    ctrl_reset = 1'b0;
    s_reset    = 1'b0;
    tick();

    // Basic write/read and r0
    wr(5'd5, 32'hDEADBEEF);
    ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd0; #1;
    check("r5_A", data_readRegA, 32'hDEADBEEF);
    check("r0_B", data_readRegB, 32'h0);
    wr(5'd0, 32'h1);
    ctrl_readRegA = 5'd0; #1;
    check("r0_write_ignored", data_readRegA, 32'h0);

    // Same-cycle write and read of r7
    ctrl_readRegA = 5'd7;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h12345678; #1;
`ifdef REGFILE_BYPASS_EN
    check("r7_before_edge", data_readRegA, 32'h12345678);
`else
    check("r7_before_edge", data_readRegA, 32'h0);
`endif
    tick();
    ctrl_writeEnable = 1'b0; #1;
    check("r7_after_edge", data_readRegA, 32'h12345678);

    // Scoreboard on r9
    ctrl_setBusy = 1'b1; ctrl_busyReg = 5'd9;
    tick();
    ctrl_setBusy = 1'b0;
    ctrl_readRegA = 5'd9; ctrl_readRegB = 5'd9; #1;
    check("busy9_A", 32'(busy_readA), 32'h1);
    check("busy9_B", 32'(busy_readB), 32'h1);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'hA5; #1;
`ifdef REGFILE_BYPASS_EN
    check("busy9_during_write", 32'(busy_readA), 32'h0);
`else
    check("busy9_during_write", 32'(busy_readA), 32'h1);
`endif
    tick();
    ctrl_writeEnable = 1'b0; #1;
    check("busy9_cleared", 32'(busy_readA), 32'h0);
    check("r9_data", data_readRegA, 32'hA5);
    ctrl_setBusy = 1'b1; ctrl_busyReg = 5'd9;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'hA5;
    tick();
    ctrl_setBusy = 1'b0; ctrl_writeEnable = 1'b0; #1;
    check("busy9_set_and_write", 32'(busy_readA), 32'h1);
    check("r9_set_and_write", data_readRegA, 32'hA5);
    ctrl_setBusy = 1'b1; ctrl_busyReg = 5'd0;
    tick();
    ctrl_setBusy = 1'b0;
    ctrl_readRegA = 5'd0; #1;
    check("busy0_never", 32'(busy_readA), 32'h0);

    // Fill r1..r31, mark r12 busy, then bulk-clear
    for (int i = 1; i < 32; i++) wr(5'(i), 32'h1000_0000 + 32'(i));
    ctrl_readRegA = 5'd31; #1;
    check("fill_r31", data_readRegA, 32'h1000_001F);
    ctrl_setBusy = 1'b1; ctrl_busyReg = 5'd12;
    tick();
    ctrl_setBusy = 1'b0;
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
    n_act = 0;
    for (int c = 0; c < 40; c++) begin
      if (!clear_active) break;
      n_act++;
      if (n_act == 5) begin
        ctrl_readRegA = 5'd31; ctrl_readRegB = 5'd2; #1;
        check("partial_r31", data_readRegA, 32'h1000_001F);
        check("partial_r2", data_readRegB, 32'h0);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h33;
        ctrl_clear = 1'b1;
      end
      tick();
      ctrl_writeEnable = 1'b0;
      ctrl_clear = 1'b0;
    end
    check("clear_cycles", 32'(n_act), 32'd31);
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i); #1;
      check($sformatf("cleared_r%0d", i), data_readRegA, 32'h0);
    end
    ctrl_readRegA = 5'd12; #1;
    check("cleared_busy12", 32'(busy_readA), 32'h0);

    // Reset in the middle of a clear
    wr(5'd5, 32'h55);
    wr(5'd30, 32'h30);
    ctrl_setBusy = 1'b1; ctrl_busyReg = 5'd6;
    tick();
    ctrl_setBusy = 1'b0;
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("midclear_active", 32'(clear_active), 32'h1);
    ctrl_reset = 1'b1;
    ctrl_readRegA = 5'd30; ctrl_readRegB = 5'd6; #1;
    check("abort_active", 32'(clear_active), 32'h0);
    check("abort_r30", data_readRegA, 32'h0);
    check("abort_busy6", 32'(busy_readB), 32'h0);
    #2;
    ctrl_reset = 1'b0;
    tick();
    wr(5'd4, 32'h44);
    ctrl_readRegA = 5'd4; #1;
    check("post_reset_write", data_readRegA, 32'h44);
    check("post_reset_idle", 32'(clear_active), 32'h0);

    // Narrow instance: 16-bit, 8 registers
    s_we = 1'b1; s_wr = 3'd7; s_wdata = 16'hFFFF;
    tick();
    s_we = 1'b0; s_ra = 3'd7; #1;
    check("small_r7", 32'(s_rdata_a), 32'h0000FFFF);
    s_we = 1'b1; s_wr = 3'd0; s_wdata = 16'h1234;
    tick();
    s_we = 1'b0; s_ra = 3'd0; #1;
    check("small_r0", 32'(s_rdata_a), 32'h0);
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    n_act = 0;
    for (int c = 0; c < 20; c++) begin
      if (!s_active) break;
      n_act++;
      tick();
    end
    check("small_clear_cycles", 32'(n_act), 32'd7);
    s_ra = 3'd7; #1;
    check("small_r7_cleared", 32'(s_rdata_a), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
